// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter: CPU loads/stores share one synchronous memory
// port with the VGA scan-out fetcher. The CPU has priority. A bounded-wait
// counter forces a VGA grant after MAX_WAIT lost cycles, and a saturating
// counter records CPU stall cycles for debug.
module dmem_port_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4,
  parameter int SCW      = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           cpu_req,
  input  logic           cpu_we,
  input  logic [AW-1:0]  cpu_addr,
  input  logic [DW-1:0]  cpu_wdata,
  output logic           cpu_stall,
  output logic           cpu_rvalid,
  output logic [DW-1:0]  cpu_rdata,
  input  logic           vga_req,
  input  logic [AW-1:0]  vga_addr,
  output logic           vga_gnt,
  output logic           vga_rvalid,
  output logic [DW-1:0]  vga_rdata,
  output logic           mem_en,
  output logic           mem_we,
  output logic [AW-1:0]  mem_addr,
  output logic [DW-1:0]  mem_wdata,
  input  logic [DW-1:0]  mem_rdata,
  output logic [SCW-1:0] stall_count
);

  typedef enum logic [1:0] {
    RSP_NONE = 2'd0,
    RSP_CPU  = 2'd1,
    RSP_VGA  = 2'd2
  } rsp_e;

  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

  logic [3:0]     wait_q, wait_d;
  rsp_e           rsp_q, rsp_d;
  logic [SCW-1:0] stall_q, stall_d;

  logic force_vga;
  logic cpu_gnt;

  // Same-cycle grant decision and memory port drive
  always_comb begin
    force_vga = vga_req && (wait_q == MAX_W);
    cpu_gnt   = cpu_req && !force_vga;
    vga_gnt   = vga_req && (force_vga || !cpu_req);
    cpu_stall = cpu_req && force_vga;

    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_en    = 1'b1;
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (vga_gnt) begin
      mem_en    = 1'b1;
      mem_addr  = vga_addr;
    end
  end

  // Next-state for the wait counter, response owner and stall counter
  always_comb begin
    wait_d = '0;
    if (vga_req && !vga_gnt)
      wait_d = (wait_q == MAX_W) ? wait_q : wait_q + 4'd1;

    rsp_d = RSP_NONE;
    if (cpu_gnt && !cpu_we)
      rsp_d = RSP_CPU;
    else if (vga_gnt)
      rsp_d = RSP_VGA;

    stall_d = stall_q;
    if (cpu_stall && (stall_q != '1))
      stall_d = stall_q + SCW'(1);
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_q  <= '0;
      rsp_q   <= RSP_NONE;
      stall_q <= '0;
    end else begin
      wait_q  <= wait_d;
      rsp_q   <= rsp_d;
      stall_q <= stall_d;
    end
  end

  // A response still in flight when reset arrives is suppressed in the
  // reset cycle itself, so a read granted just before reset never shows rvalid.
  assign cpu_rvalid  = (rsp_q == RSP_CPU) && !reset;
  assign vga_rvalid  = (rsp_q == RSP_VGA) && !reset;
  assign cpu_rdata   = mem_rdata;
  assign vga_rdata   = mem_rdata;
  assign stall_count = stall_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: behavioural memory, a reference model of the
// arbitration rules checked every cycle, and directed scenarios with literal
// expectations.
module tb_dmem_port_arbiter;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int MW = 4;
  localparam int SC = 4;
  localparam int SAT = (1 << SC) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_stall, cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          vga_req;
  logic [AW-1:0] vga_addr;
  logic          vga_gnt, vga_rvalid;
  logic [DW-1:0] vga_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [SC-1:0] stall_count;

  int checks = 0;
  int errors = 0;

  dmem_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MW), .SCW(SC)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt),
    .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  // Behavioural single-port memory with 1-cycle registered read
  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: cycles VGA has been kept waiting, expected response
  // owner/data for the next cycle, total stalls, and a shadow memory.
  logic [DW-1:0] ref_mem [256];
  int            lost      = 0;
  int            exp_rsp   = 0;   // 0 none, 1 cpu, 2 vga
  logic [DW-1:0] exp_rdata = '0;
  int            stalls    = 0;

  function automatic logic m_force();
    return vga_req && (lost == MW);
  endfunction

  always @(posedge clk) begin : model_upd
    logic fv, vg, cg;
    fv = m_force();
    vg = vga_req && (fv || !cpu_req);
    cg = cpu_req && !fv;
    if (reset) begin
      lost = 0; exp_rsp = 0; stalls = 0;
    end else begin
      lost = (vga_req && !vg) ? lost + 1 : 0;
      if (cg && !cpu_we) begin
        exp_rsp = 1; exp_rdata = ref_mem[cpu_addr];
      end else if (vg) begin
        exp_rsp = 2; exp_rdata = ref_mem[vga_addr];
      end else begin
        exp_rsp = 0;
      end
      if (cpu_req && fv) stalls++;
    end
    if (cg && cpu_we) ref_mem[cpu_addr] = cpu_wdata;
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin : model_cmp
    logic fv, vg, cg;
    logic [AW-1:0] ea;
    fv = m_force();
    vg = vga_req && (fv || !cpu_req);
    cg = cpu_req && !fv;
    ea = cg ? cpu_addr : (vg ? vga_addr : '0);
    chk("vga_gnt",   {31'd0, vga_gnt},   {31'd0, vg});
    chk("cpu_stall", {31'd0, cpu_stall}, {31'd0, cpu_req && fv});
    chk("mem_en",    {31'd0, mem_en},    {31'd0, cg || vg});
    chk("mem_we",    {31'd0, mem_we},    {31'd0, cg && cpu_we});
    chk("mem_addr",  {24'd0, mem_addr},  {24'd0, ea});
    chk("mem_wdata", mem_wdata,          cg ? cpu_wdata : 32'd0);
    chk("cpu_rvalid", {31'd0, cpu_rvalid}, {31'd0, exp_rsp == 1 && !reset});
    chk("vga_rvalid", {31'd0, vga_rvalid}, {31'd0, exp_rsp == 2 && !reset});
    if (exp_rsp == 1 && !reset) chk("cpu_rdata", cpu_rdata, exp_rdata);
    if (exp_rsp == 2 && !reset) chk("vga_rdata", vga_rdata, exp_rdata);
    chk("stall_count", {28'd0, stall_count}, (stalls > SAT) ? SAT : stalls);
  end

  task automatic set_in(input logic cr, input logic cw, input logic [AW-1:0] ca,
                        input logic [DW-1:0] cd, input logic vr,
                        input logic [AW-1:0] va, input logic rst);
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    vga_req = vr; vga_addr = va; reset = rst;
    #1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = (i * 32'h0101_0101) ^ 32'h5A5A_0000;
      ref_mem[i] = (i * 32'h0101_0101) ^ 32'h5A5A_0000;
    end
    mem[8'h20]     = 32'h0000_00A5;
    ref_mem[8'h20] = 32'h0000_00A5;
    mem_rdata      = '0;

    // Reset with both requests low
    set_in(0, 0, 0, 0, 0, 0, 1);
    tick(); tick();
    set_in(0, 0, 0, 0, 0, 0, 0);
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd0);
    chk("rst_vga_rvalid", {31'd0, vga_rvalid}, 32'd0);
    chk("rst_stall_count", {28'd0, stall_count}, 32'd0);
    tick();

    // CPU store then load back
    set_in(1, 1, 8'h10, 32'hDEADBEEF, 0, 0, 0);
    chk("st_mem_we", {31'd0, mem_we}, 32'd1);
    tick();
    set_in(1, 0, 8'h10, 32'h0, 0, 0, 0);
    chk("ld_mem_en", {31'd0, mem_en}, 32'd1);
    chk("ld_stall", {31'd0, cpu_stall}, 32'd0);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0);
    chk("ld_rvalid", {31'd0, cpu_rvalid}, 32'd1);
    chk("ld_rdata", cpu_rdata, 32'hDEADBEEF);
    tick();

    // VGA alone
    set_in(0, 0, 0, 0, 1, 8'h20, 0);
    chk("vga_solo_gnt", {31'd0, vga_gnt}, 32'd1);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0);
    chk("vga_solo_rvalid", {31'd0, vga_rvalid}, 32'd1);
    chk("vga_solo_rdata", vga_rdata, 32'h0000_00A5);
    tick();
    chk("vga_solo_once", {31'd0, vga_rvalid}, 32'd0);

    // Both held: forced VGA grants at cycles 4 and 9
    for (int c = 0; c < 10; c++) begin
      set_in(1, 0, AW'(c), 0, 1, 8'h30, 0);
      chk("cont_gnt", {31'd0, vga_gnt}, (c == 4 || c == 9) ? 32'd1 : 32'd0);
      chk("cont_stall", {31'd0, cpu_stall}, (c == 4 || c == 9) ? 32'd1 : 32'd0);
      if (c == 4) chk("cont_addr", {24'd0, mem_addr}, 32'h30);
      if (c == 5) chk("cont_rvalid", {31'd0, vga_rvalid}, 32'd1);
      tick();
    end
    set_in(0, 0, 0, 0, 0, 0, 0);
    chk("cont_stall_count", {28'd0, stall_count}, 32'd2);
    tick();

    // VGA drops at cycle 2, re-raises at 3: forced grant at cycle 7
    for (int c = 0; c < 8; c++) begin
      set_in(1, 0, 8'h01, 0, (c != 2), 8'h40, 0);
      chk("drop_gnt", {31'd0, vga_gnt}, (c == 7) ? 32'd1 : 32'd0);
      tick();
    end
    set_in(0, 0, 0, 0, 0, 0, 0);
    chk("drop_stall_count", {28'd0, stall_count}, 32'd3);
    tick();

    // Reset in the cycle after a VGA grant
    set_in(0, 0, 0, 0, 1, 8'h20, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 1);
    chk("rstrd_rvalid", {31'd0, vga_rvalid}, 32'd0);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0);
    chk("rstrd_rvalid2", {31'd0, vga_rvalid}, 32'd0);
    chk("rstrd_stall_count", {28'd0, stall_count}, 32'd0);
    tick();

    // Saturation: 17 forced stalls over 85 cycles with SCW=4
    for (int c = 0; c < 85; c++) begin
      set_in(1, 0, 8'h02, 0, 1, 8'h50, 0);
      if (c == 4) chk("sat_first_force", {31'd0, vga_gnt}, 32'd1);
      tick();
    end
    set_in(0, 0, 0, 0, 0, 0, 0);
    chk("sat_stall_count", {28'd0, stall_count}, 32'hF);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
